// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D sweep sequencer: state encoding,
// field widths and SPI command word construction.
package a2d_pkg;

  localparam int CH_W   = 3;
  localparam int RES_W  = 12;
  localparam int CMD_W  = 16;
  localparam int MAX_CH = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEL      = 3'd1,
    S_WAIT_SEL = 3'd2,
    S_GAP      = 3'd3,
    S_RD       = 3'd4,
    S_WAIT_RD  = 3'd5,
    S_CAP      = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [CH_W-1:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic logic [CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] mask);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/a2d_sweep_seq_if.sv
// Handshake between the sweep sequencer and the 16-bit SPI master.
interface a2d_sweep_seq_if;
  import a2d_pkg::*;

  logic             wrt;
  logic [CMD_W-1:0] cmd;
  logic             done;
  logic [CMD_W-1:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);

endinterface

// File: rtl/a2d_period_tmr.sv
// Free-running auto-sweep timer: one-cycle tick every PERIOD clocks, silent when PERIOD is 0.
module a2d_period_tmr #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [23:0] RELOAD = (PERIOD <= 0) ? 24'd0 : 24'(PERIOD - 1);

  logic [23:0] cnt;

  // Down-counter: terminal count at zero reloads, so the tick repeats every PERIOD clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 24'd1;
    end
  end

  assign tick = (PERIOD > 0) && (cnt == '0);

endmodule

// File: rtl/a2d_sweep_seq.sv
// Sweeps the enabled channels of an external 8-channel 12-bit SPI A2D, two
// transactions per channel (select, then read), into a per-channel result file.
//
// state      | meaning
// S_IDLE     | waiting for strt or period tick (registered into go_q)
// S_SEL      | wrt for the channel-select transaction
// S_WAIT_SEL | waiting for done of the select transaction
// S_GAP      | dly_cnt down to 0; gap_to_rd picks RD (after select) or SEL (next channel)
// S_RD       | wrt for the sample-read transaction
// S_WAIT_RD  | waiting for done of the read transaction
// S_CAP      | capture rd_data into res[ch], retire channel from mask
// S_FIN      | sweep_done pulse
module a2d_sweep_seq
  import a2d_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 8,
  parameter int PERIOD  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt,
  input  logic [MAX_CH-1:0] chnl_en,
  a2d_sweep_seq_if.master   spi,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [RES_W-1:0]  rd_res,
  output logic              busy,
  output logic              sweep_done
);

  localparam int                DLY_W    = $clog2(GAP_CYC + 1);
  localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(GAP_CYC);
  localparam logic [MAX_CH-1:0] CH_MASK  = MAX_CH'((1 << NUM_CH) - 1);

  state_t             state, state_nx;
  logic               go_q;
  logic               tick;
  logic [MAX_CH-1:0]  mask, mask_nx;
  logic [MAX_CH-1:0]  start_mask, mask_left;
  logic [CH_W-1:0]    ch, ch_nx;
  logic [DLY_W-1:0]   dly_cnt, dly_nx;
  logic               gap_to_rd, gap_rd_nx;
  logic [RES_W-1:0]   res [MAX_CH];

  a2d_period_tmr #(.PERIOD(PERIOD)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign start_mask = chnl_en & CH_MASK;
  assign mask_left  = mask & ~(MAX_CH'(1) << ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      go_q      <= 1'b0;
      mask      <= '0;
      ch        <= '0;
      dly_cnt   <= '0;
      gap_to_rd <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) res[i] <= '0;
    end else begin
      state     <= state_nx;
      // Requests outside IDLE are dropped here, so nothing queues behind a sweep.
      go_q      <= (strt | tick) && (state == S_IDLE);
      mask      <= mask_nx;
      ch        <= ch_nx;
      dly_cnt   <= dly_nx;
      gap_to_rd <= gap_rd_nx;
      if (state == S_CAP) res[ch] <= spi.rd_data[RES_W-1:0];
    end
  end

  always_comb begin
    state_nx  = state;
    mask_nx   = mask;
    ch_nx     = ch;
    dly_nx    = dly_cnt;
    gap_rd_nx = gap_to_rd;
    case (state)
      S_IDLE: begin
        if (go_q) begin
          mask_nx  = start_mask;
          ch_nx    = lowest_set(start_mask);
          state_nx = (start_mask == '0) ? S_FIN : S_SEL;
        end
      end
      S_SEL:      state_nx = S_WAIT_SEL;
      S_WAIT_SEL: begin
        if (spi.done) begin
          dly_nx    = DLY_LOAD;
          gap_rd_nx = 1'b1;
          state_nx  = S_GAP;
        end
      end
      S_GAP: begin
        if (dly_cnt == '0) state_nx = gap_to_rd ? S_RD : S_SEL;
        else               dly_nx   = dly_cnt - DLY_W'(1);
      end
      S_RD:       state_nx = S_WAIT_RD;
      S_WAIT_RD:  if (spi.done) state_nx = S_CAP;
      S_CAP: begin
        mask_nx = mask_left;
        if (mask_left == '0) begin
          state_nx = S_FIN;
        end else begin
          ch_nx     = lowest_set(mask_left);
          dly_nx    = DLY_LOAD;
          gap_rd_nx = 1'b0;
          state_nx  = S_GAP;
        end
      end
      S_FIN:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  assign spi.wrt    = (state == S_SEL) || (state == S_RD);
  assign spi.cmd    = mk_cmd(ch);
  assign busy       = (state != S_IDLE);
  assign sweep_done = (state == S_FIN);
  assign rd_res     = (int'(rd_ch) < NUM_CH) ? res[rd_ch] : '0;

endmodule
